// File: rtl/median_seq.sv
// Sequencer for a compare-exchange median sorter: loads SIZE samples, runs (SIZE-1)/2+1 compare passes, strobes DSO.
// Optional sticky protocol-error flag ERR is built only when MEDIAN_SEQ_ERR_EN is defined.
module median_seq #(
   parameter int SIZE = 9
) (
   input  logic clk,
   input  logic nRST,
   input  logic DSI,
   output logic MED_DSI,
   output logic MED_BYP,
   output logic DSO,
   output logic BUSY
`ifdef MEDIAN_SEQ_ERR_EN
   ,
   output logic ERR
`endif
);

   localparam int CNT_W  = $clog2(SIZE);
   localparam int PASS_W = $clog2((SIZE + 1) / 2);

   localparam logic [CNT_W-1:0]  LAST_LOAD = CNT_W'(SIZE - 1);
   localparam logic [CNT_W-1:0]  LAST_CMP  = CNT_W'(SIZE - 2);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'((SIZE - 1) / 2);

   typedef enum logic [2:0] {IDLE, LOAD, CMP, BYP, DONE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [PASS_W-1:0]   r_pass;
   logic                r_dso;
   logic                r_busy;
   logic                r_byp;
   logic                w_loadPhase;

   // Outputs are registered against the next state; defaults cover the common case.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pass  <= '0;
         r_dso   <= 1'b0;
         r_busy  <= 1'b0;
         r_byp   <= 1'b1;
      end else begin
         r_dso  <= 1'b0;
         r_busy <= 1'b1;
         r_byp  <= 1'b1;
         case (r_state)
            IDLE, DONE: begin
               r_pass <= '0;
               if (DSI) begin
                  r_state <= LOAD;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            LOAD: begin
               if (!DSI) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_pass  <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == LAST_LOAD) begin
                  r_state <= CMP;
                  r_cnt   <= '0;
                  r_pass  <= '0;
                  r_byp   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            CMP: begin
               if (r_cnt == LAST_CMP) begin
                  r_cnt <= '0;
                  if (r_pass < LAST_PASS) begin
                     r_state <= BYP;
                  end else begin
                     r_state <= DONE;
                     r_dso   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  r_byp <= 1'b0;
               end
            end
            BYP: begin
               r_state <= CMP;
               r_cnt   <= '0;
               r_pass  <= r_pass + PASS_W'(1);
               r_byp   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_pass  <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Gating with nRST keeps the sorter quiet for the whole reset cycle, not just after the edge.
   assign w_loadPhase = (r_state == IDLE) || (r_state == LOAD) || (r_state == DONE);
   assign MED_DSI     = DSI & w_loadPhase & nRST;
   assign MED_BYP     = r_byp | ~nRST;
   assign DSO         = r_dso & nRST;
   assign BUSY        = r_busy & nRST;

`ifdef MEDIAN_SEQ_ERR_EN
   logic r_err;

   // Sticky: an aborted load or a strobe during sorting means the upstream framing is broken.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         r_err <= 1'b0;
      end else if (((r_state == LOAD) && !DSI) ||
                   (((r_state == CMP) || (r_state == BYP)) && DSI)) begin
         r_err <= 1'b1;
      end
   end

   assign ERR = r_err;
`endif

endmodule

// File: tb/tb_median_seq.sv
// Directed self-checking bench for median_seq (SIZE = 9); also checks ERR when MEDIAN_SEQ_ERR_EN is defined.
module tb_median_seq;

   logic clk = 1'b0;
   logic nRST;
   logic DSI;
   logic MED_DSI;
   logic MED_BYP;
   logic DSO;
   logic BUSY;
`ifdef MEDIAN_SEQ_ERR_EN
   logic ERR;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int pixel;
   int captured[$];
   int starts[$];
   bit dsiPlan[0:127];
   int pixTab[9] = '{10, 50, 30, 90, 20, 70, 40, 80, 60};

   always #5 clk = ~clk;

   median_seq #(.SIZE(9)) dut (
      .clk     (clk),
      .nRST    (nRST),
      .DSI     (DSI),
      .MED_DSI (MED_DSI),
      .MED_BYP (MED_BYP),
      .DSO     (DSO),
      .BUSY    (BUSY)
`ifdef MEDIAN_SEQ_ERR_EN
      ,
      .ERR     (ERR)
`endif
   );

   // Expected behaviour of one window started at cycle s: DONE at s+53, BYP at s+17/26/35/44.
   function automatic bit expBusy(int c);
      foreach (starts[i]) if (c >= starts[i] + 1 && c <= starts[i] + 53) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit expDso(int c);
      foreach (starts[i]) if (c == starts[i] + 53) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit inSortPhase(int c);
      foreach (starts[i]) if (c - starts[i] >= 9 && c - starts[i] <= 52) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit expByp(int c);
      int d;
      foreach (starts[i]) begin
         d = c - starts[i];
         if (d >= 9 && d <= 52 && ((d - 9) % 9) != 8) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int medianOf(input int q[$]);
      if (q.size() == 0) return -1;
      for (int i = 1; i < q.size(); i++) begin
         for (int j = i; j > 0 && q[j-1] > q[j]; j--) begin
            int t;
            t      = q[j];
            q[j]   = q[j-1];
            q[j-1] = t;
         end
      end
      return q[q.size() / 2];
   endfunction

   task automatic applyStimulus(input bit dsi, input bit rstN, input int pix);
      @(posedge clk);
      #1;
      DSI   = dsi;
      nRST  = rstN;
      pixel = pix;
      @(negedge clk);
      if (MED_DSI === 1'b1) captured.push_back(pixel);
   endtask

   task automatic checkBit(input string tag, input int c, input logic obs, input logic exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input int c, input bit eDso, input bit eBusy,
                              input bit eByp, input bit eMed, input bit eErr);
      checkBit({tag, ".DSO"}, c, DSO, eDso);
      checkBit({tag, ".BUSY"}, c, BUSY, eBusy);
      checkBit({tag, ".MED_BYP"}, c, MED_BYP, eByp);
      checkBit({tag, ".MED_DSI"}, c, MED_DSI, eMed);
`ifdef MEDIAN_SEQ_ERR_EN
      checkBit({tag, ".ERR"}, c, ERR, eErr);
`else
      if (eErr) testsRun += 0;
`endif
   endtask

   task automatic runWindows(input string tag, input int first, input int last, input int errFrom);
      bit d;
      for (int c = first; c <= last; c++) begin
         d = dsiPlan[c];
         applyStimulus(d, 1'b1, (c < 9) ? pixTab[c] : 0);
         checkOutput(tag, c, expDso(c), expBusy(c), expByp(c), d && !inSortPhase(c),
                     errFrom >= 0 && c >= errFrom);
      end
   endtask

   task automatic resetDut();
      applyStimulus(1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 0);
      captured.delete();
      starts.delete();
      foreach (dsiPlan[i]) dsiPlan[i] = 1'b0;
   endtask

   initial begin
      nRST  = 1'b0;
      DSI   = 1'b0;
      pixel = 0;

      // Reset held with DSI high: everything quiet, bypass selected
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 0);
         checkOutput("reset", i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 0);
         checkOutput("idle", i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end

      // Nominal window with the reference pixels
      resetDut();
      for (int c = 0; c < 9; c++) dsiPlan[c] = 1'b1;
      starts.push_back(0);
      runWindows("nominal", 0, 53, -1);
      checkInt("nominal.samples", captured.size(), 9);
      checkInt("nominal.median", medianOf(captured), 50);
      runWindows("nominal", 54, 57, -1);

      // Back-to-back windows
      resetDut();
      for (int c = 0; c < 9; c++) dsiPlan[c] = 1'b1;
      for (int c = 53; c < 62; c++) dsiPlan[c] = 1'b1;
      starts.push_back(0);
      starts.push_back(53);
      runWindows("b2b", 0, 109, -1);

      // Load abort after five samples
      resetDut();
      for (int c = 0; c <= 10; c++) begin
         applyStimulus(c < 5, 1'b1, 0);
         checkOutput("abort", c, 1'b0, (c >= 1 && c <= 5), 1'b1, (c < 5), (c >= 6));
      end

      // Stray strobes while sorting
      resetDut();
      for (int c = 0; c < 9; c++) dsiPlan[c] = 1'b1;
      dsiPlan[20] = 1'b1;
      dsiPlan[35] = 1'b1;
      starts.push_back(0);
      runWindows("stray", 0, 57, 21);

      // Reset mid-sort, then a fresh window on the first cycle after release
      resetDut();
      for (int c = 0; c < 9; c++) dsiPlan[c] = 1'b1;
      for (int c = 31; c < 40; c++) dsiPlan[c] = 1'b1;
      starts.push_back(0);
      runWindows("midrst", 0, 29, -1);
      applyStimulus(1'b0, 1'b0, 0);
      checkOutput("midrst", 30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      starts.delete();
      starts.push_back(31);
      runWindows("midrst", 31, 87, -1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
